// File: rtl/alu_exec_ctrl_pkg.sv
// Shared definitions for the execute/write-back controller.
// Holds datapath widths, ALU operation codes, the controller state
// encoding and the immediate sign-extension helper.
package alu_exec_ctrl_pkg;

    localparam int DATA_W     = 18;
    localparam int REG_ADDR_W = 4;
    localparam int REG_COUNT  = 16;
    localparam int IMM_W      = 6;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_WB   = 2'b10
    } state_t;

    function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/alu_exec_ctrl_regfile_16x18.sv
// 16 x 18-bit register file.
// Ports:
//   clk, rst_n            clock, asynchronous active-low clear of all registers
//   i_we, i_waddr, i_wdata synchronous write port
//   i_raddr_a/o_rdata_a   combinational read port A
//   i_raddr_b/o_rdata_b   combinational read port B
//   i_dbg_addr/o_dbg_data combinational debug read port
// R0 reads as zero and ignores writes.
module regfile_16x18
    import alu_exec_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_we,
    input  logic [REG_ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [REG_ADDR_W-1:0] i_raddr_a,
    output logic [DATA_W-1:0]     o_rdata_a,
    input  logic [REG_ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0]     o_rdata_b,
    input  logic [REG_ADDR_W-1:0] i_dbg_addr,
    output logic [DATA_W-1:0]     o_dbg_data
);

    logic [DATA_W-1:0] r_mem [REG_COUNT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Reads of R0 are forced to zero rather than relying on the storage.
    assign o_rdata_a  = (i_raddr_a  == '0) ? '0 : r_mem[i_raddr_a];
    assign o_rdata_b  = (i_raddr_b  == '0) ? '0 : r_mem[i_raddr_b];
    assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute/write-back controller in front of the 18-bit ALU.
// Accepts one decoded instruction per valid/ready handshake, presents
// registered operands/op to the external ALU, captures its result and
// writes it back one cycle later. One instruction every 3 cycles at best.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   instr_valid/instr_ready       instruction handshake
//   instr_op/rd/rs1/rs2/use_imm/imm decoded instruction fields
//   alu_a/alu_b/alu_op            registered ALU operands and operation
//   alu_result                    combinational ALU result
//   wb_valid/wb_rd/wb_data        write-back pulse and contents
//   dbg_addr/dbg_data             combinational register-file debug read
module alu_exec_ctrl
    import alu_exec_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [1:0]            instr_op,
    input  logic [REG_ADDR_W-1:0] instr_rd,
    input  logic [REG_ADDR_W-1:0] instr_rs1,
    input  logic [REG_ADDR_W-1:0] instr_rs2,
    input  logic                  instr_use_imm,
    input  logic [IMM_W-1:0]      instr_imm,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [1:0]            alu_op,
    input  logic [DATA_W-1:0]     alu_result,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0]     wb_data,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]     dbg_data
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_accept;
    logic                  w_wb;
    logic [DATA_W-1:0]     w_rs1_data;
    logic [DATA_W-1:0]     w_rs2_data;
    logic [DATA_W-1:0]     r_alu_a;
    logic [DATA_W-1:0]     r_alu_b;
    logic [1:0]            r_alu_op;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0]     r_result;

    regfile_16x18 u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (w_wb),
        .i_waddr    (r_rd),
        .i_wdata    (r_result),
        .i_raddr_a  (instr_rs1),
        .o_rdata_a  (w_rs1_data),
        .i_raddr_b  (instr_rs2),
        .o_rdata_b  (w_rs2_data),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_wb        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (instr_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_WB;
            end
            ST_WB: begin
                w_wb        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operands hold their value from EXEC until the next acceptance so the
    // ALU inputs stay quiet while the controller is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= OP_ADD;
            r_rd     <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_alu_a  <= w_rs1_data;
                r_alu_b  <= instr_use_imm ? sext_imm(instr_imm) : w_rs2_data;
                r_alu_op <= instr_op;
                r_rd     <= instr_rd;
            end
            if (r_state == ST_EXEC) begin
                r_result <= alu_result;
            end
        end
    end

    assign instr_ready = (r_state == ST_IDLE);
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_op      = r_alu_op;

    // Write-back outputs read zero outside the WB pulse.
    assign wb_valid = w_wb;
    assign wb_rd    = w_wb ? r_rd : '0;
    assign wb_data  = w_wb ? r_result : '0;

endmodule
